step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 176 +++++++++++++++++
 tb/tb_step_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: hardwired control unit for a single-bus datapath.
// Each instruction is a fixed Moore sequence: fetch in T0..T2, then register/ALU
// steps in T3..T5. Every strobe is decoded from the registered state. Only the
// register selects and Alu_op also look at the IR input.
//
// Ports:
//   Clock, Reset_n      clock and synchronous active-low reset
//   Run                 level; keep fetching and executing while high
//   IR                  current instruction register
//                       (opcode, Ra, Rb and Rc fields from the MSB down)
//   Mem_ready           memory read-complete strobe (wait-state build only)
//   PCout..Yin          single-bit datapath strobes
//   Rin, Rout           one-hot register load/drive selects
//   Alu_op              ALU operation; equals the opcode in T4, else 0
//   Done                one-cycle pulse per retired instruction
//   Illegal             sticky bad-opcode flag, cleared only by reset
//   Instr_count         saturating count of retired instructions
//
// Build option: define SEQ_MEM_WAIT_EN to stretch T1 until Mem_ready is seen.
module step_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_SEL_W  = 4,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned REG_COUNT = 2 ** REG_SEL_W
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Run,
    input  logic [DATA_W-1:0]    IR,
    input  logic                 Mem_ready,
    output logic                 PCout,
    output logic                 MARin,
    output logic                 IncPC,
    output logic                 Zin,
    output logic                 ZLOout,
    output logic                 PCin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic [REG_COUNT-1:0] Rin,
    output logic [REG_COUNT-1:0] Rout,
    output logic [4:0]           Alu_op,
    output logic                 Done,
    output logic                 Illegal,
    output logic [CNT_W-1:0]     Instr_count
);

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5} state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]           opcode;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic                 opcode_ok;

    assign opcode    = IR[DATA_W-1 -: 5];
    assign ra        = IR[DATA_W-6 -: REG_SEL_W];
    assign rb        = IR[DATA_W-6-REG_SEL_W -: REG_SEL_W];
    assign rc        = IR[DATA_W-6-2*REG_SEL_W -: REG_SEL_W];
    assign opcode_ok = (opcode >= 5'd3) && (opcode <= 5'd10);

    // Low IR bits below Rc carry no control information.
    logic unused_ir;
    assign unused_ir = ^IR;

    function automatic logic [REG_COUNT-1:0] one_hot(input logic [REG_SEL_W-1:0] idx);
        logic [REG_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin       = 1'b0;
        ZLOout    = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Rin       = '0;
        Rout      = '0;
        Alu_op    = 5'd0;
        Done      = 1'b0;

        case (state_q)
            StIdle: begin
                // A latched illegal opcode parks the sequencer until reset.
                if (Run && !illegal_q) begin
                    state_d = StT0;
                end
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
                state_d = Mem_ready ? StT2 : StT1;
`else
                state_d = StT2;
`endif
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                Rout = one_hot(rb);
                Yin  = 1'b1;
                if (opcode_ok) begin
                    state_d = StT4;
                end else begin
                    state_d   = StIdle;
                    illegal_d = 1'b1;
                end
            end
            StT4: begin
                Rout    = one_hot(rc);
                Zin     = 1'b1;
                Alu_op  = opcode;
                state_d = StT5;
            end
            StT5: begin
                ZLOout  = 1'b1;
                Rin     = one_hot(ra);
                Done    = 1'b1;
                count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                state_d = Run ? StT0 : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifndef SEQ_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = Mem_ready;
`endif

    assign Illegal     = illegal_q;
    assign Instr_count = count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized bench for step_sequencer. The reference model expands each
// instruction into its list of per-cycle output steps from the phase table. Every
// cycle the stimulus pushes the expected output vector into a scoreboard. A
// separate monitor pops it on the falling edge and compares it with the DUT.
module tb_step_sequencer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_SEL_W = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned RC        = 16;
    localparam int unsigned VW        = 11 + 2 * RC + 5 + 2 + CNT_W;

    // Strobe order: PCout MARin IncPC Zin ZLOout PCin Read MDRin MDRout IRin Yin
    localparam logic [10:0] S_T0  = 11'b111_1000_0000;
    localparam logic [10:0] S_T1  = 11'b000_0111_1000;
    localparam logic [10:0] S_T2  = 11'b000_0000_0110;
    localparam logic [10:0] S_T3  = 11'b000_0000_0001;
    localparam logic [10:0] S_T4  = 11'b000_1000_0000;
    localparam logic [10:0] S_T5  = 11'b000_0100_0000;

    logic              Clock = 1'b0;
    logic              Reset_n, Run, Mem_ready;
    logic [DATA_W-1:0] IR;
    logic PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [RC-1:0]     Rin, Rout;
    logic [4:0]        Alu_op;
    logic              Done, Illegal;
    logic [CNT_W-1:0]  Instr_count;

    always #5 Clock = ~Clock;

    step_sequencer #(
        .DATA_W    (DATA_W),
        .REG_SEL_W (REG_SEL_W),
        .CNT_W     (CNT_W)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Run         (Run),
        .IR          (IR),
        .Mem_ready   (Mem_ready),
        .PCout       (PCout),
        .MARin       (MARin),
        .IncPC       (IncPC),
        .Zin         (Zin),
        .ZLOout      (ZLOout),
        .PCin        (PCin),
        .Read        (Read),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .IRin        (IRin),
        .Yin         (Yin),
        .Rin         (Rin),
        .Rout        (Rout),
        .Alu_op      (Alu_op),
        .Done        (Done),
        .Illegal     (Illegal),
        .Instr_count (Instr_count)
    );

    logic [VW-1:0] actual;
    assign actual = {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin,
                     Rin, Rout, Alu_op, Done, Illegal, Instr_count};

    typedef struct packed {
        logic [10:0]       strb;
        logic [RC-1:0]     rin;
        logic [RC-1:0]     rout;
        logic [4:0]        alu;
        logic              done;
        logic              ill_end;
        logic              mr;
        logic [DATA_W-1:0] ir;
    } step_t;

    step_t         plan[$];
    logic [VW-1:0] sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic          m_illegal;
    logic [CNT_W-1:0] m_count;

    // Expand one instruction into the output steps it must produce.
    function automatic void build_plan(input logic [DATA_W-1:0] ir);
        step_t      s;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic       legal;
        int         w;
        op    = ir[31:27];
        ra    = ir[26:23];
        rb    = ir[22:19];
        rc    = ir[18:15];
        legal = (op >= 5'd3) && (op <= 5'd10);
        s      = '0;
        s.ir   = ir;
        s.mr   = 1'($urandom_range(0, 1));
        s.strb = S_T0;
        plan.push_back(s);
`ifdef SEQ_MEM_WAIT_EN
        w = $urandom_range(0, 3);
`else
        w = 0;
`endif
        for (int i = 0; i <= w; i++) begin
            s.strb = S_T1;
`ifdef SEQ_MEM_WAIT_EN
            s.mr = (i == w);
`else
            s.mr = 1'($urandom_range(0, 1));
`endif
            plan.push_back(s);
        end
        s.mr   = 1'($urandom_range(0, 1));
        s.strb = S_T2;
        plan.push_back(s);
        s.strb     = S_T3;
        s.rout     = '0;
        s.rout[rb] = 1'b1;
        s.ill_end  = !legal;
        plan.push_back(s);
        if (legal) begin
            s.ill_end  = 1'b0;
            s.strb     = S_T4;
            s.rout     = '0;
            s.rout[rc] = 1'b1;
            s.alu      = op;
            plan.push_back(s);
            s.strb     = S_T5;
            s.rout     = '0;
            s.alu      = 5'd0;
            s.rin[ra]  = 1'b1;
            s.done     = 1'b1;
            plan.push_back(s);
        end
    endfunction

    function automatic logic [DATA_W-1:0] next_ir();
        logic [4:0] op;
        op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 10));
        return {op, 27'($urandom)};
    endfunction

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge Clock) begin
        logic [VW-1:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (actual !== e) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got %h expected %h", cyc, actual, e);
            end
        end
    end

    initial begin
        step_t         cur;
        logic [VW-1:0] e;
        logic          rst, run;
        Reset_n   = 1'b0;
        Run       = 1'b0;
        IR        = '0;
        Mem_ready = 1'b0;
        m_illegal = 1'b0;
        m_count   = '0;
        repeat (2) @(posedge Clock);
        #1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (plan.size() > 0) begin
                cur       = plan[0];
                IR        = cur.ir;
                Mem_ready = cur.mr;
                e = {cur.strb, cur.rin, cur.rout, cur.alu, cur.done, m_illegal, m_count};
            end else begin
                cur       = '0;
                Mem_ready = 1'($urandom_range(0, 1));
                e         = '0;
                e[CNT_W]  = m_illegal;
                e[CNT_W-1:0] = m_count;
            end
            sb.push_back(e);

            rst = (cyc >= 8) && (($urandom_range(0, 59) == 0) ||
                                 (m_illegal && ($urandom_range(0, 5) == 0)));
            run = (cyc < 8) || ($urandom_range(0, 99) < 85);
            Reset_n = !rst;
            Run     = run;

            if (rst) begin
                plan.delete();
                m_illegal = 1'b0;
                m_count   = '0;
            end else if (plan.size() > 0) begin
                void'(plan.pop_front());
                if (cur.ill_end) m_illegal = 1'b1;
                if (cur.done) begin
                    if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
                    if (run) build_plan(next_ir());
                end
            end else if (run && !m_illegal) begin
                build_plan((cyc == 0) ? 32'h3A18_8000 : next_ir());
            end
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
